// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the CPU data-SRAM responder: port widths, FSM encoding
// and the byte-strobe to bit-mask helper used by the bypass merge.
package data_sram_responder_pkg;

  localparam int DSRAM_WE_WID   = 4;
  localparam int DSRAM_ADDR_WID = 32;
  localparam int DSRAM_DATA_WID = 32;

  typedef enum logic {
    DSR_CLEAR = 1'b0,
    DSR_RUN   = 1'b1
  } dsr_state_e;

  function automatic logic [DSRAM_DATA_WID-1:0] strb_mask(input logic [DSRAM_WE_WID-1:0] strb);
    logic [DSRAM_DATA_WID-1:0] m;
    for (int i = 0; i < DSRAM_WE_WID; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/data_sram_responder_array.sv
// DEPTH x 32 word RAM: one synchronous read port (read-first) and one
// byte-strobed write port. The read register holds when rd_en_i is low.
module dsram_array
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      rd_en_i,
  input  logic [ADDR_W-1:0]         rd_idx_i,
  output logic [DSRAM_DATA_WID-1:0] rd_data_o,
  input  logic [DSRAM_WE_WID-1:0]   wr_strb_i,
  input  logic [ADDR_W-1:0]         wr_idx_i,
  input  logic [DSRAM_DATA_WID-1:0] wr_data_i
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DSRAM_DATA_WID-1:0] mem_q [DEPTH];
  logic [DSRAM_DATA_WID-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DSRAM_WE_WID; i++) begin
      if (wr_strb_i[i]) mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
    end
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: clear sweep FSM, 1-entry posted write buffer with
// store-to-load bypass, registered read data and saturating access counters.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      data_sram_en,
  input  logic [DSRAM_WE_WID-1:0]   data_sram_we,
  input  logic [DSRAM_ADDR_WID-1:0] data_sram_addr,
  input  logic [DSRAM_DATA_WID-1:0] data_sram_wdata,
  output logic [DSRAM_DATA_WID-1:0] data_sram_rdata,
  output logic                      sram_ready,
  output logic [15:0]               rd_cnt,
  output logic [15:0]               wr_cnt,
  output dsr_state_e                dbg_state_o
);

  dsr_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         clr_idx_q, clr_idx_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]         wb_idx_q, wb_idx_d;
  logic [DSRAM_DATA_WID-1:0] wb_data_q, wb_data_d;
  logic [DSRAM_WE_WID-1:0]   wb_strb_q, wb_strb_d;
  logic [DSRAM_DATA_WID-1:0] byp_mask_q, byp_mask_d;
  logic [DSRAM_DATA_WID-1:0] byp_data_q, byp_data_d;
  logic [15:0]               rd_cnt_q, rd_cnt_d;
  logic [15:0]               wr_cnt_q, wr_cnt_d;

  logic [ADDR_W-1:0]         req_idx;
  logic                      rd_acc, wr_acc;
  logic [DSRAM_WE_WID-1:0]   arr_wr_strb;
  logic [ADDR_W-1:0]         arr_wr_idx;
  logic [DSRAM_DATA_WID-1:0] arr_wr_data;
  logic [DSRAM_DATA_WID-1:0] arr_rd_data;
  logic                      unused_addr;

  // Handshake: a request is accepted in any cycle where sram_ready and data_sram_en
  // are both high; there is no back-pressure, requests seen while not ready are dropped.
  assign req_idx     = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[DSRAM_ADDR_WID-1:ADDR_W+2], data_sram_addr[1:0]};
  assign rd_acc      = (state_q == DSR_RUN) && data_sram_en && (data_sram_we == '0);
  assign wr_acc      = (state_q == DSR_RUN) && data_sram_en && (data_sram_we != '0);

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wb_valid_d  = 1'b0;
    wb_idx_d    = wb_idx_q;
    wb_data_d   = wb_data_q;
    wb_strb_d   = wb_strb_q;
    byp_mask_d  = byp_mask_q;
    byp_data_d  = byp_data_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    arr_wr_strb = '0;
    arr_wr_idx  = wb_idx_q;
    arr_wr_data = wb_data_q;
    unique case (state_q)
      DSR_CLEAR: begin
        if (INIT_CLEAR) begin
          arr_wr_strb = '1;
          arr_wr_idx  = clr_idx_q;
          arr_wr_data = '0;
          clr_idx_d   = clr_idx_q + ADDR_W'(1);
          if (&clr_idx_q) state_d = DSR_RUN;
        end else begin
          state_d = DSR_RUN;
        end
      end
      DSR_RUN: begin
        // The buffered write drains every cycle it is valid, even while a new one is captured.
        if (wb_valid_q) arr_wr_strb = wb_strb_q;
        if (wr_acc) begin
          wb_valid_d = 1'b1;
          wb_idx_d   = req_idx;
          wb_data_d  = data_sram_wdata;
          wb_strb_d  = data_sram_we;
          if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (rd_acc) begin
          byp_mask_d = (wb_valid_q && (wb_idx_q == req_idx)) ? strb_mask(wb_strb_q) : '0;
          byp_data_d = wb_data_q;
          if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = DSR_CLEAR;
    endcase
    if (!rstn) arr_wr_strb = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= DSR_CLEAR;
      clr_idx_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_strb_q  <= '0;
      byp_mask_q <= '1;
      byp_data_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_strb_q  <= wb_strb_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  dsram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk       (clk),
    .rd_en_i   (rd_acc),
    .rd_idx_i  (req_idx),
    .rd_data_o (arr_rd_data),
    .wr_strb_i (arr_wr_strb),
    .wr_idx_i  (arr_wr_idx),
    .wr_data_i (arr_wr_data)
  );

  // An all-ones bypass mask after reset forces rdata to zero without resetting the RAM.
  assign data_sram_rdata = (arr_rd_data & ~byp_mask_q) | (byp_data_q & byp_mask_q);
  assign sram_ready      = (state_q == DSR_RUN);
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: word-level memory model, expected-read queue
// and a negedge monitor comparing rdata the cycle after each accepted read.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic [15:0] rd_cnt, wr_cnt;
  dsr_state_e  dbg_state;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(ADDR_W), .INIT_CLEAR(1'b1)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .sram_ready      (ready),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .dbg_state_o     (dbg_state)
  );

  logic [31:0] exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_rd, mdl_wr;
  bit          mdl_ready;
  bit          rd_flag, chk_q;
  int          checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  // Monitor: a read accepted at posedge N has its response checked at the following negedge.
  always @(posedge clk) chk_q <= rd_flag;
  always @(negedge clk) begin
    if (chk_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: got %h with no expected read outstanding", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // Driver: present one request for one cycle and update the reference model if accepted.
  task automatic issue(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d; rd_flag = 1'b0;
    if (mdl_ready && e) begin
      if (w == 4'h0) begin
        exp_q.push_back(mdl_mem[midx(a)]);
        rd_flag = 1'b1;
        if (mdl_rd < 65535) mdl_rd++;
      end else begin
        for (int i = 0; i < 4; i++) if (w[i]) mdl_mem[midx(a)][8*i +: 8] = d[8*i +: 8];
        if (mdl_wr < 65535) mdl_wr++;
      end
    end
    @(negedge clk);
    en = 1'b0; we = 4'h0; rd_flag = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rstn = 1'b0; mdl_ready = 1'b0;
    en = 1'b0; we = 4'h0; rd_flag = 1'b0;
    repeat (hold) @(negedge clk);
    foreach (mdl_mem[i]) mdl_mem[i] = 32'h0;
    mdl_rd = 0; mdl_wr = 0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_rd_cnt", 32'(rd_cnt), 32'h0);
    check("reset_wr_cnt", 32'(wr_cnt), 32'h0);
    rstn = 1'b1;
  endtask

  // Follow the clear sweep after reset release; optionally throw requests at it.
  task automatic sweep(input bit junk, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      if (junk && !mdl_ready)
        issue(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      else
        issue(1'b0, 4'h0, 32'h0, 32'h0);
      check("sweep_ready", 32'(ready), (k >= DEPTH) ? 32'h1 : 32'h0);
      if (k < DEPTH) begin
        check("sweep_rdata_held", rdata, 32'h0);
        check("sweep_rd_cnt", 32'(rd_cnt), 32'h0);
        check("sweep_wr_cnt", 32'(wr_cnt), 32'h0);
      end
      if (k == DEPTH) mdl_ready = 1'b1;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 4'h0, 32'(i * 4), 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0;
    @(negedge clk);

    // Clear sweep with requests thrown at it, then every word reads zero.
    do_reset(3);
    sweep(1'b1, DEPTH + 2);
    check("state_run", 32'(dbg_state), 32'(DSR_RUN));
    read_all();

    // Full-word write then immediate read of the same word (bypass).
    issue(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    issue(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);

    // Partial-lane write merged with array contents.
    issue(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 4'b0100, 32'h0000_0020, 32'h00AA_0000);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 4'h0, 32'h0000_0020, 32'h0);

    // Back-to-back partial writes to one word, read immediately and again later.
    issue(1'b1, 4'hF, 32'h0000_0040, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 4'b0001, 32'h0000_0040, 32'h0000_0055);
    issue(1'b1, 4'b1000, 32'h0000_0040, 32'h6600_0000);
    issue(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    check("dir_rd_cnt", 32'(rd_cnt), 32'(mdl_rd));
    check("dir_wr_cnt", 32'(wr_cnt), 32'(mdl_wr));

    // Reset mid-sweep, then reset with a write still sitting in the buffer.
    rstn = 1'b0;
    do_reset(1);
    sweep(1'b1, 5);
    do_reset(2);
    sweep(1'b0, DEPTH + 2);
    issue(1'b1, 4'hF, 32'h0000_000C, 32'hCAFE_F00D);
    do_reset(1);
    sweep(1'b1, DEPTH + 2);
    read_all();

    // Randomised mix of reads, writes and idle cycles with aliased addresses.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] w;
      w = (($urandom_range(0, 2)) == 0) ? 4'h0 :
          (($urandom_range(0, 1)) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 3) != 0), w, $urandom, $urandom);
    end
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    check("rand_rd_cnt", 32'(rd_cnt), 32'(mdl_rd));
    check("rand_wr_cnt", 32'(wr_cnt), 32'(mdl_wr));

    // Drive the read counter past saturation.
    for (int n = 0; n < 70000; n++) issue(1'b1, 4'h0, $urandom, 32'h0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    check("sat_rd_cnt", 32'(rd_cnt), 32'h0000_FFFF);
    check("sat_rd_cnt_mdl", 32'(rd_cnt), 32'(mdl_rd));
    check("sat_wr_cnt", 32'(wr_cnt), 32'(mdl_wr));

    issue(1'b0, 4'h0, 32'h0, 32'h0);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
